// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch_unit and memory.
// One request may be outstanding at a time; the response carries no tag.
interface fetch_unit_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              resp_valid;
   logic [INST_W-1:0] resp_data;

   modport master (
      output req_valid, req_addr,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch feeding the IF/ID register.
// Keeps one memory request in flight, buffers returned instructions in a
// DEPTH-entry circular queue and presents the head to ID. A redirect clears
// the queue and restarts fetch at redirect_pc; a response that belongs to a
// request issued before the redirect is thrown away.
// Optional build macro FETCH_PERF_EN adds two saturating performance counters.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | nothing outstanding; may issue a request
// ST_WAIT | request outstanding, its response will be enqueued
// ST_DROP | request outstanding, its response is stale and will be dropped
module fetch_unit #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              if_wr_en,
   output logic              if_stall,
   output logic [INST_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc,
   fetch_unit_if.master      mem
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_empty_cycles,
   output logic [31:0]       perf_dropped_resps
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DROP
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];

   logic empty;
   logic req_fire;
   logic resp_take;
   logic enq;
   logic drop;
   logic pop;

   assign empty = (count == '0);

   // Request only when idle and the queue has room for the answer; the
   // reset term keeps req_valid low for the whole time reset is held.
   assign mem.req_valid = !reset && (state == ST_IDLE) &&
                          (count < CNT_W'(DEPTH)) && !redirect_valid;
   assign mem.req_addr  = fetch_pc;

   assign req_fire  = mem.req_valid && mem.req_ready;
   assign resp_take = mem.resp_valid && (state != ST_IDLE);
   assign enq       = resp_take && (state == ST_WAIT) && !redirect_valid;
   assign drop      = resp_take && !enq;
   assign pop       = if_wr_en && !empty && !redirect_valid;

   assign if_stall = empty;
   assign if_inst  = empty ? '0 : inst_q[head];
   assign if_pc    = empty ? '0 : pc_q[head];

   // Outstanding/discard tracking: next state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_fire)            state_nxt = ST_WAIT;
         ST_WAIT: if (mem.resp_valid)      state_nxt = ST_IDLE;
                  else if (redirect_valid) state_nxt = ST_DROP;
         ST_DROP: if (mem.resp_valid)      state_nxt = ST_IDLE;
         default:                          state_nxt = ST_IDLE;
      endcase
   end

   // State register, fetch PC and the tag of the in-flight request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         state <= state_nxt;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
         end else if (req_fire) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
         end
         if (req_fire) begin
            req_pc <= fetch_pc;
         end
      end
   end

   // Queue pointers and occupancy; redirect empties the queue outright.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PTR_W'(1);
         if (pop) head <= head + PTR_W'(1);
         case ({enq, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_q[tail]   <= req_pc;
         inst_q[tail] <= mem.resp_data;
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating counters: stalled cycles and discarded responses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_empty_cycles  <= '0;
         perf_dropped_resps <= '0;
      end else begin
         if (empty && (perf_empty_cycles != '1)) begin
            perf_empty_cycles <= perf_empty_cycles + 32'd1;
         end
         if (drop && (perf_dropped_resps != '1)) begin
            perf_dropped_resps <= perf_dropped_resps + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: deterministic table for the start-up sequence,
// hand-written redirect/full-queue/reset sequences, then random traffic
// checked against a queue-based reference model and a tb-side memory.
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [63:0] RST_PC   = 64'h1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        if_wr_en = 1'b0;
   logic        if_stall;
   logic [31:0] if_inst;
   logic [63:0] if_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_empty_cycles;
   logic [31:0] perf_dropped_resps;
`endif

   fetch_unit_if #(.ADDR_W(64), .INST_W(32)) bus ();

   fetch_unit #(
      .DEPTH(DEPTH), .ADDR_W(64), .INST_W(32), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .if_wr_en(if_wr_en),
      .if_stall(if_stall),
      .if_inst(if_inst),
      .if_pc(if_pc),
      .mem(bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_empty_cycles(perf_empty_cycles),
      .perf_dropped_resps(perf_dropped_resps)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model
   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } ent_t;
   ent_t        q[$];
   logic [63:0] m_fetch_pc;
   logic [63:0] stream_pc;
   bit          m_stale;
   bit          mem_busy;
   int          mem_wait;
   logic [63:0] mem_addr;
   int          lat = 1;

   // last sampled DUT values
   logic        s_rv;
   logic [63:0] s_addr;
   logic        s_stall;
   logic [63:0] s_pc;

   typedef struct {
      bit          redir;
      logic [63:0] rpc;
      bit          wr;
      bit          rdy;
      bit          e_rv;
      logic [63:0] e_addr;
      bit          e_stall;
      logic [63:0] e_pc;
   } vec_t;
   vec_t vt[17];

   function automatic logic [31:0] inst_of(logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5EED_0001;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic do_reset(int cyc);
      @(negedge clk);
      #2;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      if_wr_en       = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
      #1;
      chk("rst_if_stall", {63'd0, if_stall}, 64'd1);
      chk("rst_if_inst", {32'd0, if_inst}, 64'd0);
      chk("rst_if_pc", if_pc, 64'd0);
      chk("rst_req_valid", {63'd0, bus.req_valid}, 64'd0);
      q.delete();
      m_fetch_pc = RST_PC;
      stream_pc  = RST_PC;
      m_stale    = 1'b0;
      mem_busy   = 1'b0;
      mem_wait   = 0;
      repeat (cyc) @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // One clock cycle: drive at negedge, compare, then advance the model.
   task automatic step(input bit redir, input logic [63:0] rpc, input bit wr,
                       input bit rdy, input bit junk);
      bit resp, exp_rv, fire, pop, busy0;
      @(negedge clk);
      resp           = mem_busy && (mem_wait == 0);
      redirect_valid = redir;
      redirect_pc    = rpc;
      if_wr_en       = wr;
      bus.req_ready  = rdy;
      bus.resp_valid = resp || (junk && !mem_busy);
      bus.resp_data  = resp ? inst_of(mem_addr) : 32'hBAD0_BAD0;
      exp_rv         = !mem_busy && (q.size() < DEPTH) && !redir;
      #1;
      s_rv    = bus.req_valid;
      s_addr  = bus.req_addr;
      s_stall = if_stall;
      s_pc    = if_pc;
      chk("if_stall", {63'd0, if_stall}, {63'd0, q.size() == 0});
      chk("if_pc", if_pc, (q.size() != 0) ? q[0].pc : 64'd0);
      chk("if_inst", {32'd0, if_inst}, {32'd0, (q.size() != 0) ? q[0].inst : 32'd0});
      chk("req_valid", {63'd0, bus.req_valid}, {63'd0, exp_rv});
      if (exp_rv) chk("req_addr", bus.req_addr, m_fetch_pc);
      if (wr && !redir && (q.size() != 0)) begin
         chk("stream_pc", if_pc, stream_pc);
         stream_pc = stream_pc + 64'd4;
      end
      fire  = exp_rv && rdy;
      pop   = wr && (q.size() != 0) && !redir;
      busy0 = mem_busy;
      @(posedge clk);
      if (redir) begin
         q.delete();
         m_fetch_pc = rpc;
         stream_pc  = rpc;
      end else begin
         if (pop) void'(q.pop_front());
         if (resp && !m_stale) q.push_back('{pc: mem_addr, inst: inst_of(mem_addr)});
      end
      if (resp) m_stale = 1'b0;
      else if (redir && busy0) m_stale = 1'b1;
      if (resp) mem_busy = 1'b0;
      else if (mem_busy && (mem_wait > 0)) mem_wait--;
      if (fire) begin
         mem_busy   = 1'b1;
         mem_wait   = lat - 1;
         mem_addr   = m_fetch_pc;
         m_fetch_pc = m_fetch_pc + 64'd4;
      end
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [63:0] rpc;
      vt[0]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h1000, 1'b1, 64'h0};
      vt[1]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 64'h0};
      vt[2]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h1004, 1'b0, 64'h1000};
      vt[3]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1000};
      vt[4]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h1008, 1'b0, 64'h1000};
      vt[5]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1000};
      vt[6]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h100C, 1'b0, 64'h1000};
      vt[7]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1000};
      vt[8]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1000};
      vt[9]  = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1000};
      vt[10] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h1010, 1'b0, 64'h1004};
      vt[11] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1008};
      vt[12] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h1014, 1'b0, 64'h100C};
      vt[13] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0,    1'b0, 64'h1010};
      vt[14] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h1018, 1'b0, 64'h1014};
      vt[15] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0,    1'b1, 64'h0};
      vt[16] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h101C, 1'b0, 64'h1018};

      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;

      // start-up table: fill to DEPTH, then stream
      do_reset(2);
      lat = 1;
      for (int i = 0; i < 17; i++) begin
         step(vt[i].redir, vt[i].rpc, vt[i].wr, vt[i].rdy, 1'b0);
         chk($sformatf("tbl%0d_rv", i), {63'd0, s_rv}, {63'd0, vt[i].e_rv});
         if (vt[i].e_rv) chk($sformatf("tbl%0d_addr", i), s_addr, vt[i].e_addr);
         chk($sformatf("tbl%0d_stall", i), {63'd0, s_stall}, {63'd0, vt[i].e_stall});
         chk($sformatf("tbl%0d_pc", i), s_pc, vt[i].e_pc);
      end

      // redirect while a 3-cycle request is outstanding
      lat = 3;
      for (int i = 0; i < 20 && !(mem_busy && mem_wait == 2); i++) step(0, 0, 1, 1, 0);
      chk("A_fresh_req", {63'd0, mem_busy && mem_wait == 2}, 64'd1);
      step(1, 64'h2000, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("A_stall_wait", {63'd0, s_stall}, 64'd1);
      step(0, 0, 0, 1, 0);
      chk("A_drop_stall", {63'd0, s_stall}, 64'd1);
      chk("A_drop_norv", {63'd0, s_rv}, 64'd0);
      step(0, 0, 0, 1, 0);
      chk("A_req_rv", {63'd0, s_rv}, 64'd1);
      chk("A_req_addr", s_addr, 64'h2000);
      repeat (4) step(0, 0, 0, 1, 0);
      chk("A_head_stall", {63'd0, s_stall}, 64'd0);
      chk("A_head_pc", s_pc, 64'h2000);

      // redirect in the same cycle as a live response
      lat = 1;
      for (int i = 0; i < 20 && !(mem_busy && mem_wait == 0 && !m_stale); i++)
         step(0, 0, 1, 1, 0);
      chk("B_resp_due", {63'd0, mem_busy && mem_wait == 0}, 64'd1);
      step(1, 64'h3000, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("B_req_rv", {63'd0, s_rv}, 64'd1);
      chk("B_req_addr", s_addr, 64'h3000);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      chk("B_head_stall", {63'd0, s_stall}, 64'd0);
      chk("B_head_pc", s_pc, 64'h3000);

      // full queue, then pop and enqueue in the same cycle
      lat = 2;
      for (int i = 0; i < 60 && !(q.size() == DEPTH && !mem_busy); i++) step(0, 0, 0, 1, 0);
      chk("C_full", q.size(), DEPTH);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0, 0);
         if (s_stall) break;
         n++;
      end
      chk("C_entries_after", n, DEPTH - 1);

      // reset with a request outstanding; its late response must be ignored
      lat = 4;
      for (int i = 0; i < 20 && !(mem_busy && mem_wait == 3); i++) step(0, 0, 0, 1, 0);
      chk("D_inflight", {63'd0, mem_busy}, 64'd1);
      do_reset(1);
      step(0, 0, 0, 0, 1);
      chk("D_stall", {63'd0, s_stall}, 64'd1);
      chk("D_rv", {63'd0, s_rv}, 64'd1);
      chk("D_addr", s_addr, RST_PC);
      step(0, 0, 0, 0, 1);
      chk("D_still_empty", {63'd0, s_stall}, 64'd1);
      repeat (10) step(0, 0, 1, 1, 0);

      // random traffic, including redirects near the top of the address space
      for (int i = 0; i < 3000; i++) begin
         lat = $urandom_range(1, 4);
         if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
         else rpc = {32'h0, $urandom & 32'hFFFF_FFFC};
         step($urandom_range(0, 99) < 4, rpc, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 3) != 0), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Issues sequential instruction-memory requests, buffers returned instructions in a small queue, and presents the head instruction to ID. Drives `if_stall` into pipeline traffic control and consumes its `if_wr_en`. Redirects (jumps, flushes) discard queued and in-flight instructions and restart fetch at a new PC.

## Interface
- `DEPTH`, 4, fetch-queue entries (power of two, ≥2)
- `ADDR_W`, 64, PC / address width
- `INST_W`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `redirect_valid`  in  1  flush/jump from a later stage; restart fetch
- `redirect_pc`  in  ADDR_W  new fetch address
- `if_wr_en`  in  1  IF/ID register accepts this cycle (from traffic control)
- `if_stall`  out  1  queue empty; no instruction available
- `if_inst`  out  INST_W  head instruction (0 when empty)
- `if_pc`  out  ADDR_W  head PC (0 when empty)
- `req_valid`  out  1  memory fetch request
- `req_addr`  out  ADDR_W  request address
- `req_ready`  in  1  memory accepts request
- `resp_valid`  in  1  response for the single outstanding request
- `resp_data`  in  INST_W  fetched instruction

## Operation
- State: `fetch_pc`, `outstanding` (0/1), `discard` flag, circular queue of {pc, inst} with head/tail pointers and count (0..DEPTH).
- Request: `req_valid` = !outstanding && (count + outstanding < DEPTH) && !redirect_valid; `req_addr` = fetch_pc. Handshake fires on `req_valid && req_ready`: outstanding←1, fetch_pc←fetch_pc+4 (wraps modulo 2^ADDR_W).
- Response: when `resp_valid` and outstanding: outstanding←0; if !discard and no redirect this cycle, enqueue {pc of request, resp_data} at tail; else drop, discard←0.
- Pop: `if_wr_en && !if_stall` with no redirect removes head.
- Simultaneous pop and enqueue: count unchanged, both pointers advance. Pop never enabled when empty; enqueue never occurs when full (guaranteed by request rule).
- Redirect (highest priority): queue cleared (count←0, pointers←0), fetch_pc←redirect_pc, pop and enqueue suppressed. If a request is outstanding and not answered this cycle, discard←1. Redirect in cycle of a response drops that response; discard stays 0.
- `if_wr_en` asserted by traffic control during a flush is ignored for popping when redirect_valid is high.
- Request address of in-flight request stored in a register for tagging the enqueued entry.

## Timing
- Reset (async assert): fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0; outputs `if_stall`=1, `if_inst`=0, `if_pc`=0, `req_valid`=0 while reset high.
- First `req_valid` in first cycle after reset deasserts.
- Response to visible head: 1 cycle (enqueue at edge, `if_stall` low next cycle).
- Redirect to new request: `req_valid` with redirect_pc in cycle after redirect if nothing outstanding; else cycle after the discarded response returns.
- Outputs `if_stall`, `if_inst`, `if_pc`, `req_valid`, `req_addr` depend only on registers plus `redirect_valid` (no path from `if_wr_en`, `req_ready`, `resp_*`).
- Reset mid-transfer: in-flight response arriving after reset is ignored (outstanding=0).

## Configuration
- `FETCH_PERF_EN`: when defined, adds outputs `perf_empty_cycles` and `perf_dropped_resps` (32-bit, reset 0, saturating): count cycles with `if_stall`=1 outside reset, and responses dropped by discard or same-cycle redirect. When undefined, ports and counters absent; functional behaviour identical.

## Test plan
- Reset, RESET_PC=0x1000, req_ready=1, 1-cycle response, if_wr_en=0 -> requests 0x1000,0x1004,0x1008,0x100C, then req_valid=0 with count=4; head pc=0x1000.
- Then if_wr_en=1 continuously -> if_pc sequence 0x1000,0x1004,... one per cycle once streaming; no duplicates or gaps.
- Redirect to 0x2000 while request 0x1010 outstanding, response 3 cycles later -> that response dropped, if_stall=1 until 0x2000 instruction arrives; next request addr 0x2000.
- Redirect in same cycle as response -> response dropped, discard stays 0, next response to 0x2000 enqueued.
- Full queue, if_wr_en=1 and resp simultaneously -> count stays constant, order preserved.
- Reset asserted with request outstanding, response returns after reset -> ignored, queue empty, fetch restarts at RESET_PC.
